btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Upstream stage between the raw board push-buttons (btnC/U/D/R/L) and the board-level logic that consumes them (seg/dp drive, future menu/counter logic).
- Synchronises each asynchronous button to clk and debounces it.
- Produces a clean level per button, plus one-cycle press, release and auto-repeat strobes.
- Replaces direct use of raw button pins in downstream logic.

Parameters:
- N_BTN, 5, number of buttons; bit map 0=C, 1=U, 2=D, 3=R, 4=L.
- DEBOUNCE_CYCLES, 1000000, consecutive cycles of disagreement required to accept a new level (10 ms at 100 MHz); legal range >= 1.
- REPEAT_DELAY, 50000000, cycles a button must be held after its press strobe before the first repeat strobe; 0 disables auto-repeat.
- REPEAT_RATE, 10000000, cycles between successive repeat strobes; legal range >= 1.

Ports:
- clk, input, 1, system clock (100 MHz on board).
- rst, input, 1, synchronous active-high reset.
- btn_raw, input, N_BTN, asynchronous raw button levels, active-high.
- btn_level, output, N_BTN, debounced level.
- btn_press, output, N_BTN, one-cycle strobe on a debounced rising edge.
- btn_release, output, N_BTN, one-cycle strobe on a debounced falling edge.
- btn_repeat, output, N_BTN, one-cycle auto-repeat strobe while held.

Behaviour:
- One clock and one reset: clk, plus rst (synchronous, active-high). All state is sampled on the rising edge of clk.
- Reset:
  - Synchroniser flops, stable levels, counters and FSMs clear to 0/IDLE.
  - All outputs are 0 in the cycle after rst is sampled high.
  - Reset mid-debounce or mid-repeat discards all progress.
  - A button held through reset is treated as a fresh press once rst deasserts: the normal debounce applies, then a press strobe fires.
- Synchroniser: 2 flops per bit. sync = second flop. No logic between the two flops.
- Debounce, per bit, with a counter of width $clog2(DEBOUNCE_CYCLES):
  - If sync == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= sync and counter <= 0.
  - Else: counter <= counter+1.
- Debounce latency: a raw transition first sampled at edge k appears on btn_level after edge k+1+DEBOUNCE_CYCLES.
- Glitch rejection: any pulse or bounce shorter than DEBOUNCE_CYCLES synchronised cycles leaves btn_level unchanged, and the counter restarts from 0.
- Edge strobes:
  - btn_press = stable & ~stable_d.
  - btn_release = ~stable & stable_d.
  - stable_d is stable registered one cycle.
  - Each strobe is exactly 1 cycle wide, coincident with the first or last cycle of the level change.
- Auto-repeat FSM, per bit, with a shared-width counter sized by $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1):
  - IDLE -> WAIT on btn_press (REPEAT_DELAY != 0); counter <= 1.
  - WAIT: counter increments each cycle. When counter == REPEAT_DELAY, assert btn_repeat, go to RPT, counter <= 1.
  - RPT: counter increments each cycle. When counter == REPEAT_RATE, assert btn_repeat, counter <= 1.
  - Any state -> IDLE in the cycle btn_level is 0. No repeat strobe in that cycle.
  - With P = the press-strobe cycle, repeats occur at P+REPEAT_DELAY+n*REPEAT_RATE, n >= 0, while the button is held.
- Buttons are fully independent. Simultaneous presses or releases on several bits produce simultaneous strobes. There is no priority.
- press and repeat never coincide on the same bit.
- Outputs are registered or a single AND of registers, so downstream may use them combinationally.

Decomposition:
- Shared package btn_pkg holds:
  - BTN_C=0, BTN_U=1, BTN_D=2, BTN_R=3, BTN_L=4 index constants.
  - N_BTN=5.
  - Repeat FSM state enum {IDLE, WAIT, RPT}.
- One sub-module btn_debounce_1b: synchroniser, debounce, edge detect and repeat FSM for a single bit, with the same parameters.
- The top generates N_BTN instances.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
1. Reset: rst=1 for 3 cycles with btn_raw=5'b11111 -> all outputs 0 during and the cycle after reset. btn_level=5'b11111 after edge 5 following rst release. press=5'b11111 for 1 cycle.
2. Clean press: btn_raw[0] 0->1, first sampled edge 10 -> btn_level[0]=1 after edge 15. btn_press[0]=1 that cycle only. Release sampled edge 40 -> level 0 after edge 45. btn_release[0] pulse, 1 cycle.
3. Bounce rejection: btn_raw[2] high for 3 cycles, low 1, high 3, low -> btn_level[2], btn_press[2] and btn_release[2] stay 0 throughout.
4. Auto-repeat: hold btn_raw[3] with press strobe at cycle P -> btn_repeat[3] at P+10, P+13, P+16. Release -> no repeat after level drops, FSM in IDLE.
5. Simultaneous: btn_raw 5'b10001 rising on the same edge -> btn_press=5'b10001 in the same cycle. Staggered release of bit 4 leaves bit 0 repeats unaffected.
6. Reset mid-repeat: rst pulse while in RPT with button held -> no repeat or press during reset. Fresh press 5 cycles after release of rst, first repeat 10 cycles later.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared button indices, button count and auto-repeat FSM states
package btn_pkg;
  localparam int N_BTN = 5;
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_R = 3;
  localparam int BTN_L = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RPT} rpt_state_e;
endpackage

// File: rtl/btn_debounce_1b.sv
// btn_debounce_1b: one button; 2-flop sync, debounce, press/release edges, auto-repeat (in: clk, rst, btn_raw; out: btn_level, btn_press, btn_release, btn_repeat)
module btn_debounce_1b
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);
  localparam int DW   = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic          meta_q, sync_q, stable_q, stable_d, prev_q, rpt_q, rpt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  rpt_state_e    st_q, st_d;
  assign btn_level   = stable_q;
  assign btn_press   = stable_q & ~prev_q;
  assign btn_release = ~stable_q & prev_q;
  assign btn_repeat  = rpt_q;
  always_comb begin
    stable_d = stable_q;
    dcnt_d   = '0;
    if (sync_q != stable_q) begin
      if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) stable_d = sync_q;
      else dcnt_d = dcnt_q + 1'b1;
    end
    st_d   = st_q;
    rcnt_d = rcnt_q + 1'b1;
    if (!stable_q) begin
      st_d   = IDLE;
      rcnt_d = '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          st_d   = (btn_press && REPEAT_DELAY != 0) ? WAIT : IDLE;
          rcnt_d = (btn_press && REPEAT_DELAY != 0) ? RW'(1) : '0;
        end
        WAIT: begin
          st_d   = (rcnt_q == RW'(REPEAT_DELAY)) ? RPT : WAIT;
          rcnt_d = (rcnt_q == RW'(REPEAT_DELAY)) ? RW'(1) : rcnt_q + 1'b1;
        end
        RPT:     rcnt_d = (rcnt_q == RW'(REPEAT_RATE)) ? RW'(1) : rcnt_q + 1'b1;
        default: st_d = IDLE;
      endcase
    end
    // Look one cycle ahead so the repeat strobe leaves a flop yet lands in the
    // cycle whose state/count hit the target, and never while the level is low.
    rpt_d = stable_d && ((st_d == WAIT && rcnt_d == RW'(REPEAT_DELAY)) ||
                         (st_d == RPT  && rcnt_d == RW'(REPEAT_RATE)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      dcnt_q   <= '0;
      rcnt_q   <= '0;
      st_q     <= IDLE;
      rpt_q    <= 1'b0;
    end else begin
      meta_q   <= btn_raw;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      dcnt_q   <= dcnt_d;
      rcnt_q   <= rcnt_d;
      st_q     <= st_d;
      rpt_q    <= rpt_d;
    end
  end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button sync/debounce with level, press, release and repeat strobes (in: clk, rst, btn_raw; out: btn_level, btn_press, btn_release, btn_repeat)
module btn_conditioner #(
  parameter int N_BTN           = btn_pkg::N_BTN,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce_1b #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_btn (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_repeat (btn_repeat[i])
    );
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: scoreboard bench for btn_conditioner against a per-cycle reference model
module tb_btn_conditioner;
  localparam int N = 5, D = 4, RD = 10, RR = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] btn_raw = '0, lvl_o, prs_o, rel_o, rep_o;
  always #5 clk = ~clk;
  btn_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(lvl_o), .btn_press(prs_o), .btn_release(rel_o), .btn_repeat(rep_o)
  );
  typedef struct packed {logic [N-1:0] l, p, r, t;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, n_press = 0, n_rep = 0, cyc = 0;
  logic [N-1:0] m1 = '0, m2 = '0, ml = '0;
  int run[N], pt[N];
  bit held[N];
  always @(posedge clk) begin
    exp_t e;
    logic os, pl;
    cyc++;
    e = '0;
    for (int b = 0; b < N; b++) begin
      if (rst) begin
        m1[b] = 0; m2[b] = 0; ml[b] = 0; run[b] = 0; held[b] = 0;
      end else begin
        os = m2[b]; m2[b] = m1[b]; m1[b] = btn_raw[b]; pl = ml[b];
        if (os == pl) run[b] = 0;
        else begin
          run[b] = run[b] + 1;
          if (run[b] == D) begin ml[b] = os; run[b] = 0; end
        end
        e.l[b] = ml[b];
        e.p[b] = ml[b] & ~pl;
        e.r[b] = ~ml[b] & pl;
        if (e.p[b]) begin held[b] = 1; pt[b] = cyc; end
        if (!ml[b]) held[b] = 0;
        e.t[b] = held[b] && !e.p[b] && (cyc - pt[b] >= RD) && ((cyc - pt[b] - RD) % RR == 0);
      end
    end
    q.push_back(e);
  end
  task automatic chk(input string n, input logic [N-1:0] a, input logic [N-1:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", n, cyc, a, x);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("level", lvl_o, e.l);
      chk("press", prs_o, e.p);
      chk("release", rel_o, e.r);
      chk("repeat", rep_o, e.t);
      n_press += $countones(prs_o);
      n_rep += $countones(rep_o);
    end
  end
  task automatic hold(input logic [N-1:0] r, input logic rs, input int n);
    btn_raw = r;
    rst = rs;
    repeat (n) @(posedge clk);
    #2;
  endtask
  initial begin
    logic [N-1:0] r;
    hold(5'b11111, 1, 3);
    hold(5'b11111, 0, 20);
    hold(5'b00000, 0, 20);
    hold(5'b00001, 0, 30);
    hold(5'b00000, 0, 20);
    hold(5'b00100, 0, 3);
    hold(5'b00000, 0, 1);
    hold(5'b00100, 0, 3);
    hold(5'b00000, 0, 15);
    hold(5'b01000, 0, 40);
    hold(5'b00000, 0, 20);
    hold(5'b10001, 0, 20);
    hold(5'b00001, 0, 20);
    hold(5'b00000, 0, 15);
    hold(5'b00001, 0, 25);
    hold(5'b00001, 1, 2);
    hold(5'b00001, 0, 30);
    hold(5'b00000, 0, 15);
    r = '0;
    for (int i = 0; i < 200; i++) begin
      r = r ^ (N'($urandom) & N'($urandom));
      hold(r, $urandom_range(0, 39) == 0, ($urandom_range(0, 5) == 0) ? 30 : $urandom_range(1, 14));
    end
    hold('0, 0, 20);
    @(negedge clk);
    #1;
    chk("press_seen", (n_press > 5) ? 5'b1 : 5'b0, 5'b1);
    chk("repeat_seen", (n_rep > 3) ? 5'b1 : 5'b0, 5'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
